rf_wb_arbiter: RTL and testbench

Write-port arbiter and register scoreboard for the 32-entry integer register file in the pipelined RISC-V core. The block shares the single register-file write port between two sources: the in-order pipeline writeback stage and a long-latency unit (multiply/divide, late loads). It buffers deferred long-latency results in a small FIFO. It also tracks destination registers with an outstanding long-latency write and raises a decode stall on RAW/WAW hazards against them.

---
 rtl/rf_arb_pkg.sv | 21 ++
 rtl/rf_arb_fifo.sv | 47 ++++
 rtl/rf_wb_arbiter.sv | 119 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Register address/data widths, write record and busy-bit lookup.
package rf_arb_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } rf_wr_t;

  function automatic logic reg_hit(
    input logic [NREG-1:0]   busy,
    input logic [REG_AW-1:0] addr
  );
    return (addr != '0) && busy[addr];
  endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// Small synchronous FIFO of deferred long-latency register writes.
// Pointers carry an extra wrap bit to tell full from empty.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  rf_wr_t din,
  input  logic   pop,
  output rf_wr_t dout,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(QDEPTH);

  rf_wr_t        mem [QDEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter and long-latency scoreboard.
// Optional same-cycle result bypass: RF_ARB_BYPASS_EN.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ll_issue,
  input  logic [REG_AW-1:0] ll_issue_rd,
  input  logic              ll_res_valid,
  input  logic [REG_AW-1:0] ll_res_rd,
  input  logic [XLEN-1:0]   ll_res_data,
  output logic              ll_res_ready,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  output logic              dec_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_a3,
  output logic [XLEN-1:0]   rf_wd
);

  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nx;
  rf_wr_t            head;
  rf_wr_t            res;
  logic              full;
  logic              empty;
  logic              wb_act;
  logic              byp;
  logic              push;
  logic              pop;
  logic              ll_wr;
  logic [REG_AW-1:0] clr_rd;

  assign wb_act = wb_we && (wb_rd != '0);

`ifdef RF_ARB_BYPASS_EN
  assign byp = !wb_act && empty && ll_res_valid &&
               (ll_res_rd != '0);
`else
  assign byp = 1'b0;
`endif

  assign ll_res_ready = !full;
  assign res          = '{rd: ll_res_rd, data: ll_res_data};
  assign pop          = !wb_act && !empty;
  assign push         = ll_res_valid && !full &&
                        (ll_res_rd != '0) && !byp;
  assign ll_wr        = pop || byp;
  assign clr_rd       = pop ? head.rd : ll_res_rd;

  rf_arb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (res),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    rf_we = 1'b0;
    rf_a3 = '0;
    rf_wd = '0;
    unique case (1'b1)
      wb_act: begin
        rf_we = 1'b1;
        rf_a3 = wb_rd;
        rf_wd = wb_data;
      end
      pop: begin
        rf_we = 1'b1;
        rf_a3 = head.rd;
        rf_wd = head.data;
      end
      byp: begin
        rf_we = 1'b1;
        rf_a3 = ll_res_rd;
        rf_wd = ll_res_data;
      end
      default: ;
    endcase
  end

  // Clear first, then set, so a same-cycle reissue keeps the bit.
  always_comb begin
    busy_nx = busy;
    if (ll_wr) busy_nx[clr_rd] = 1'b0;
    if (ll_issue && (ll_issue_rd != '0))
      busy_nx[ll_issue_rd] = 1'b1;
    busy_nx[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nx;
  end

  assign dec_stall = reg_hit(busy, dec_rs1) |
                     reg_hit(busy, dec_rs2) |
                     reg_hit(busy, dec_rd);

  a_wb_busy: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(wb_act && busy[wb_rd]));

  a_issue_busy: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(ll_issue && reg_hit(busy, ll_issue_rd)));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: table, directed, random.
// Random traffic is checked against a queue/bit-array model.
module tb_rf_wb_arbiter;

  localparam int QD = 2;
`ifdef RF_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ll_issue;
  logic [4:0]  ll_issue_rd;
  logic        ll_res_valid;
  logic [4:0]  ll_res_rd;
  logic [31:0] ll_res_data;
  logic        ll_res_ready;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_stall;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;

  int n_chk;
  int n_fail;

  rf_wb_arbiter #(.QDEPTH(QD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .ll_issue     (ll_issue),
    .ll_issue_rd  (ll_issue_rd),
    .ll_res_valid (ll_res_valid),
    .ll_res_rd    (ll_res_rd),
    .ll_res_data  (ll_res_data),
    .ll_res_ready (ll_res_ready),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .dec_stall    (dec_stall),
    .rf_we        (rf_we),
    .rf_a3        (rf_a3),
    .rf_wd        (rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        iss;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_stall;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  vec_t tbl [7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_port(input string nm, input logic we,
                          input logic [4:0] a3,
                          input logic [31:0] wd);
    chk({nm, "_we"}, {31'd0, rf_we}, {31'd0, we});
    chk({nm, "_a3"}, {27'd0, rf_a3}, {27'd0, a3});
    chk({nm, "_wd"}, rf_wd, wd);
  endtask

  task automatic clr_in();
    wb_we        = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;
    ll_issue     = 1'b0;
    ll_issue_rd  = '0;
    ll_res_valid = 1'b0;
    ll_res_rd    = '0;
    ll_res_data  = '0;
    dec_rs1      = '0;
    dec_rs2      = '0;
    dec_rd       = '0;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_in();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Reference model state
  bit [31:0] mbusy;
  wr_t       mq [$];

  function automatic bit mhit(input logic [4:0] a);
    return (a != 0) && mbusy[a];
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    clr_in();

    tbl[0] = '{1, 5, 32'hA0A0_0001, 0, 0, 5, 0, 0,
               1, 5, 32'hA0A0_0001, 0};
    tbl[1] = '{1, 0, 32'hB0B0_0002, 0, 0, 0, 0, 0,
               0, 0, 32'h0, 0};
    tbl[2] = '{0, 0, 32'h0, 1, 7, 0, 7, 0,
               0, 0, 32'h0, 0};
    tbl[3] = '{0, 0, 32'h0, 0, 0, 0, 7, 0,
               0, 0, 32'h0, 1};
    tbl[4] = '{1, 4, 32'hC0C0_0003, 0, 0, 0, 0, 7,
               1, 4, 32'hC0C0_0003, 1};
    tbl[5] = '{0, 0, 32'h0, 1, 0, 0, 0, 0,
               0, 0, 32'h0, 0};
    tbl[6] = '{0, 0, 32'h0, 0, 0, 7, 0, 0,
               0, 0, 32'h0, 1};

    // Reset values, sampled during and after reset
    dec_rs1 = 5'd5;
    #3;
    chk_port("rst_hold", 0, 0, 0);
    chk("rst_hold_ready", {31'd0, ll_res_ready}, 1);
    do_reset();
    dec_rs1 = 5'd5;
    settle();
    chk_port("rst", 0, 0, 0);
    chk("rst_stall", {31'd0, dec_stall}, 0);
    chk("rst_ready", {31'd0, ll_res_ready}, 1);
    next();

    // Table vectors: writeback, x0, issue and stall terms
    for (int i = 0; i < 7; i++) begin
      wb_we       = tbl[i].wb_we;
      wb_rd       = tbl[i].wb_rd;
      wb_data     = tbl[i].wb_data;
      ll_issue    = tbl[i].iss;
      ll_issue_rd = tbl[i].iss_rd;
      dec_rs1     = tbl[i].rs1;
      dec_rs2     = tbl[i].rs2;
      dec_rd      = tbl[i].rd;
      settle();
      chk_port($sformatf("tbl%0d", i), tbl[i].e_we,
               tbl[i].e_a3, tbl[i].e_wd);
      chk($sformatf("tbl%0d_stall", i),
          {31'd0, dec_stall}, {31'd0, tbl[i].e_stall});
      next();
    end

    // Long-latency op to x7, result 0xDEADBEEF
    do_reset();
    ll_issue = 1; ll_issue_rd = 7; dec_rs2 = 7;
    settle();
    chk("x7_stall0", {31'd0, dec_stall}, 0);
    next();
    ll_issue = 0;
    settle();
    chk("x7_stall1", {31'd0, dec_stall}, 1);
    chk("x7_idle_we", {31'd0, rf_we}, 0);
    next();
    ll_res_valid = 1; ll_res_rd = 7; ll_res_data = 32'hDEADBEEF;
    settle();
    chk("x7_ready", {31'd0, ll_res_ready}, 1);
    chk_port("x7_res", BYP, BYP ? 5'd7 : 5'd0,
             BYP ? 32'hDEADBEEF : 32'h0);
    chk("x7_stall2", {31'd0, dec_stall}, 1);
    next();
    ll_res_valid = 0;
    settle();
    chk_port("x7_wr", !BYP, BYP ? 5'd0 : 5'd7,
             BYP ? 32'h0 : 32'hDEADBEEF);
    chk("x7_stall3", {31'd0, dec_stall}, {31'd0, !BYP});
    next();
    settle();
    chk("x7_stall4", {31'd0, dec_stall}, 0);
    chk("x7_we4", {31'd0, rf_we}, 0);
    next();

    // Conflict: pipeline holds the port for 3 cycles
    do_reset();
    ll_issue = 1; ll_issue_rd = 9;
    next();
    ll_issue = 0;
    wb_we = 1; wb_rd = 3; wb_data = 32'h22;
    ll_res_valid = 1; ll_res_rd = 9; ll_res_data = 32'h11;
    dec_rs1 = 9;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk_port($sformatf("cf%0d", c), 1, 3, 32'h22);
      chk($sformatf("cf%0d_stall", c), {31'd0, dec_stall}, 1);
      if (c == 0)
        chk("cf_ready", {31'd0, ll_res_ready}, 1);
      next();
      ll_res_valid = 0;
    end
    wb_we = 0;
    settle();
    chk_port("cf_x9", 1, 9, 32'h11);
    chk("cf_x9_stall", {31'd0, dec_stall}, 1);
    next();
    settle();
    chk("cf_clear", {31'd0, dec_stall}, 0);
    next();

    // Full FIFO: no write-through on the popping cycle
    do_reset();
    wb_we = 1; wb_rd = 3; wb_data = 32'h33;
    ll_res_valid = 1;
    ll_res_rd = 10; ll_res_data = 32'hA;
    settle();
    chk("fl_r1", {31'd0, ll_res_ready}, 1);
    next();
    ll_res_rd = 11; ll_res_data = 32'hB;
    settle();
    chk("fl_r2", {31'd0, ll_res_ready}, 1);
    next();
    ll_res_rd = 12; ll_res_data = 32'hC;
    settle();
    chk("fl_r3", {31'd0, ll_res_ready}, 0);
    next();
    settle();
    chk("fl_r4", {31'd0, ll_res_ready}, 0);
    chk_port("fl_wb", 1, 3, 32'h33);
    next();
    wb_we = 0;
    settle();
    chk("fl_pop_ready", {31'd0, ll_res_ready}, 0);
    chk_port("fl_p10", 1, 10, 32'hA);
    next();
    settle();
    chk("fl_ready_again", {31'd0, ll_res_ready}, 1);
    chk_port("fl_p11", 1, 11, 32'hB);
    next();
    ll_res_valid = 0;
    settle();
    chk_port("fl_p12", 1, 12, 32'hC);
    next();
    settle();
    chk("fl_empty", {31'd0, rf_we}, 0);
    next();

    // Discard: result to x0 neither writes nor clears
    do_reset();
    ll_issue = 1; ll_issue_rd = 7;
    next();
    ll_issue = 0;
    ll_res_valid = 1; ll_res_rd = 0; ll_res_data = 32'h55;
    dec_rs1 = 7;
    settle();
    chk("dc_ready", {31'd0, ll_res_ready}, 1);
    chk("dc_we", {31'd0, rf_we}, 0);
    chk("dc_stall", {31'd0, dec_stall}, 1);
    next();
    ll_res_valid = 0;
    settle();
    chk("dc_we2", {31'd0, rf_we}, 0);
    chk("dc_stall2", {31'd0, dec_stall}, 1);
    next();

    // Mid-operation reset with two queued results
    do_reset();
    wb_we = 1; wb_rd = 3; wb_data = 32'h44;
    ll_issue = 1; ll_issue_rd = 5;
    next();
    ll_issue_rd = 6;
    ll_res_valid = 1; ll_res_rd = 5; ll_res_data = 32'h5;
    next();
    ll_issue = 0;
    ll_res_rd = 6; ll_res_data = 32'h6;
    next();
    ll_res_valid = 0;
    dec_rs1 = 5; dec_rs2 = 6;
    settle();
    chk("mr_full", {31'd0, ll_res_ready}, 0);
    chk("mr_busy", {31'd0, dec_stall}, 1);
    wb_we = 0;
    rst_n = 0;
    #1;
    chk("mr_rst_we", {31'd0, rf_we}, 0);
    chk("mr_rst_ready", {31'd0, ll_res_ready}, 1);
    chk("mr_rst_stall", {31'd0, dec_stall}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    settle();
    chk("mr_we", {31'd0, rf_we}, 0);
    chk("mr_stall", {31'd0, dec_stall}, 0);
    next();
    settle();
    chk("mr_we2", {31'd0, rf_we}, 0);
    next();

    // Randomized traffic against the model
    do_reset();
    mbusy = '0;
    mq.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        wact;
      logic        e_we;
      logic [4:0]  e_a3;
      logic [31:0] e_wd;
      logic        e_rdy;
      logic        e_st;
      bit          from_q;
      bit          from_b;
      wr_t         w;

      wb_we   = ($urandom_range(0, 1) == 1);
      wb_rd   = 5'($urandom);
      wb_data = $urandom;
      if (mbusy[wb_rd]) wb_rd = 0;
      ll_issue    = ($urandom_range(0, 2) == 0);
      ll_issue_rd = 5'($urandom);
      if (mhit(ll_issue_rd)) ll_issue = 0;
      ll_res_valid = ($urandom_range(0, 1) == 1);
      ll_res_rd    = ($urandom_range(0, 7) == 0) ? 5'd0
                                                 : 5'($urandom);
      ll_res_data  = $urandom;
      dec_rs1 = 5'($urandom);
      dec_rs2 = 5'($urandom);
      dec_rd  = 5'($urandom);

      wact   = wb_we && (wb_rd != 0);
      from_q = 0;
      from_b = 0;
      e_we = 0; e_a3 = 0; e_wd = 0;
      if (wact) begin
        e_we = 1; e_a3 = wb_rd; e_wd = wb_data;
      end else if (mq.size() > 0) begin
        from_q = 1;
        e_we = 1; e_a3 = mq[0].rd; e_wd = mq[0].d;
      end else if (BYP && ll_res_valid && ll_res_rd != 0) begin
        from_b = 1;
        e_we = 1; e_a3 = ll_res_rd; e_wd = ll_res_data;
      end
      e_rdy = (mq.size() < QD);
      e_st  = mhit(dec_rs1) | mhit(dec_rs2) | mhit(dec_rd);

      settle();
      chk_port($sformatf("rnd%0d", cyc), e_we, e_a3, e_wd);
      chk($sformatf("rnd%0d_ready", cyc),
          {31'd0, ll_res_ready}, {31'd0, e_rdy});
      chk($sformatf("rnd%0d_stall", cyc),
          {31'd0, dec_stall}, {31'd0, e_st});

      if (from_q) begin
        mbusy[mq[0].rd] = 0;
        void'(mq.pop_front());
      end
      if (from_b) mbusy[ll_res_rd] = 0;
      if (ll_res_valid && e_rdy && ll_res_rd != 0 && !from_b) begin
        w.rd = ll_res_rd;
        w.d  = ll_res_data;
        mq.push_back(w);
      end
      if (ll_issue && ll_issue_rd != 0) mbusy[ll_issue_rd] = 1;
      next();
    end

    clr_in();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
